// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions.
// State encodings are reused by other pipeline control blocks; keep values fixed.
package pipe_pkg;

    typedef enum logic [1:0] {
        PIPE_EMPTY   = 2'd0,  // no entry held
        PIPE_BUSY    = 2'd1,  // main register live
        PIPE_FULL    = 2'd2,  // main and skid registers live
        PIPE_ILLEGAL = 2'd3   // unreachable; FSMs recover to EMPTY
    } pipe_state_e;

    // True when the state presents a live entry at the stage output.
    function automatic logic pipe_state_has_entry(input pipe_state_e s);
        return (s == PIPE_BUSY) || (s == PIPE_FULL);
    endfunction

endpackage

// File: rtl/pipe_skid_ctrl.sv
// Handshake FSM for the skid-buffered pipeline register.
// in_ready/out_valid are registered; load strobes are combinational for the datapath.
module pipe_skid_ctrl
    import pipe_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic in_valid,
    input  logic out_ready,
    output logic in_ready,
    output logic out_valid,
    output logic load_main,
    output logic load_skid,
    output logic main_from_skid
);

    pipe_state_e state;
    logic        acc;
    logic        drn;

    assign acc = in_valid & in_ready;
    assign drn = out_valid & out_ready;

    // Datapath load strobes for the coming edge; flush suppresses all loads.
    always_comb begin
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = (state == PIPE_FULL);
        if (!flush) begin
            case (state)
                PIPE_EMPTY: load_main = acc;
                PIPE_BUSY: begin
                    load_main = acc & drn;
                    load_skid = acc & ~drn;
                end
                PIPE_FULL:  load_main = drn;
                default: ;
            endcase
        end
    end

    // State register with registered handshake outputs; flush and illegal codes go to EMPTY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= PIPE_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else if (flush) begin
            state     <= PIPE_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                PIPE_EMPTY: begin
                    if (acc) begin
                        state     <= PIPE_BUSY;
                        out_valid <= 1'b1;
                    end
                end
                PIPE_BUSY: begin
                    if (acc && !drn) begin
                        state    <= PIPE_FULL;
                        in_ready <= 1'b0;
                    end else if (!acc && drn) begin
                        state     <= PIPE_EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                PIPE_FULL: begin
                    if (drn) begin
                        state    <= PIPE_BUSY;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= PIPE_EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with valid/ready handshake and a one-entry skid buffer.
// Optional stall statistics counter enabled by defining PIPE_SKID_STATS_EN.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned        WIDTH     = 32,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_SKID_STATS_EN
    ,
    output logic [31:0]      stall_cnt
`endif
);

    logic [WIDTH-1:0] m_data;
    logic [WIDTH-1:0] s_data;
    logic             load_main;
    logic             load_skid;
    logic             main_from_skid;

    pipe_skid_ctrl u_ctrl (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .out_ready      (out_ready),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .load_main      (load_main),
        .load_skid      (load_skid),
        .main_from_skid (main_from_skid)
    );

    // Main and skid data registers; main refills from skid when draining out of FULL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data <= RESET_VAL;
            s_data <= RESET_VAL;
        end else if (flush) begin
            m_data <= RESET_VAL;
            s_data <= RESET_VAL;
        end else begin
            if (load_main) begin
                m_data <= main_from_skid ? s_data : in_data;
            end
            if (load_skid) begin
                s_data <= in_data;
            end
        end
    end

    assign out_data = m_data;

`ifdef PIPE_SKID_STATS_EN
    // Saturating count of output stall cycles; cleared by reset only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
